mult32_seq: RTL and testbench

- Multi-cycle 32x32 integer multiplier sequencer for the RV32 M-extension ops MUL, MULH, MULHSU and MULHU.
- Sits between the execute-stage issue logic and the 8-bit unsigned multiplier array.
- Converts signed operands to magnitudes and feeds one byte of operand B per cycle into a 32x8 partial-product unit.
- Accumulates the partial products, applies the sign correction, and returns the selected 32-bit half through a valid/ready handshake.

---
 rtl/mult_pkg.sv | 26 ++
 rtl/mult32x8u.sv | 22 ++
 rtl/mult32_seq.sv | 129 ++++++++++++
 tb/tb_mult32_seq.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types for the RV32 M-extension sequential multiplier.
// Op encoding matches funct3[1:0] so issue logic can pass it straight through.
package mult_pkg;
    localparam int XLEN             = 32;
    localparam int BYTES            = XLEN / 8;
    localparam int MULT_CALC_CYCLES = 4;

    typedef enum logic [1:0] {
        MUL_LO  = 2'b00,
        MUL_HSS = 2'b01,
        MUL_HSU = 2'b10,
        MUL_HUU = 2'b11
    } mul_op_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } mult_state_t;

    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic is_signed);
        return (is_signed && v[XLEN-1]) ? (~v + 1'b1) : v;
    endfunction
endpackage

// File: rtl/mult32x8u.sv
// Combinational 32x8 unsigned partial product built from four 8x8 multipliers.
// No latency, no flow control; the sequencer presents one byte of B per cycle.
module mult32x8u
    import mult_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [7:0]      b,
    output logic [XLEN+7:0] pp
);
    logic [15:0] prod [BYTES];

    for (genvar i = 0; i < BYTES; i++) begin : g_byte_mul
        assign prod[i] = a[8*i +: 8] * b;
    end

    always_comb begin
        pp = '0;
        for (int i = 0; i < BYTES; i++) begin
            pp = pp + ({{(XLEN-8){1'b0}}, prod[i]} << (8 * i));
        end
    end
endmodule

// File: rtl/mult32_seq.sv
// Sequential RV32 MUL/MULH/MULHSU/MULHU: accept, 4 byte-accumulate cycles, sign fix, hold result.
// Result valid 6 edges after accept (counting the accept edge); result held while out_ready is low.
module mult32_seq
    import mult_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);
    localparam logic [1:0] LAST_IDX = 2'(MULT_CALC_CYCLES - 1);

    mult_state_t       state_q, state_d;
    mul_op_t           op_q, op_d;
    logic [XLEN-1:0]   mag_a_q, mag_a_d;
    logic [XLEN-1:0]   mag_b_q, mag_b_d;
    logic              neg_q, neg_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [1:0]        idx_q, idx_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              out_valid_q, out_valid_d;

    mul_op_t           op_in;
    logic              a_signed, b_signed;
    logic [7:0]        b_byte;
    logic [XLEN+7:0]   pp;
    logic [2*XLEN-1:0] prod;

    assign op_in    = mul_op_t'(op);
    assign a_signed = (op_in == MUL_HSS) || (op_in == MUL_HSU);
    assign b_signed = (op_in == MUL_HSS);
    assign b_byte   = mag_b_q[{idx_q, 3'b000} +: 8];

    mult32x8u u_pp (
        .a  (mag_a_q),
        .b  (b_byte),
        .pp (pp)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        mag_a_d     = mag_a_q;
        mag_b_d     = mag_b_q;
        neg_d       = neg_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        prod        = neg_q ? (~acc_q + 1'b1) : acc_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d    = op_in;
                    mag_a_d = abs_val(operand_a, a_signed);
                    mag_b_d = abs_val(operand_b, b_signed);
                    neg_d   = (a_signed & operand_a[XLEN-1]) ^ (b_signed & operand_b[XLEN-1]);
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = acc_q + ({{(XLEN-8){1'b0}}, pp} << {idx_q, 3'b000});
                idx_d = idx_q + 2'd1;
                if (idx_q == LAST_IDX) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d    = (op_q == MUL_LO) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A kill drops any in-flight work but leaves the last delivered result visible.
        if (flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            acc_d       = '0;
            idx_d       = '0;
            result_d    = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= MUL_LO;
            mag_a_q     <= '0;
            mag_b_q     <= '0;
            neg_q       <= 1'b0;
            acc_q       <= '0;
            idx_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            mag_a_q     <= mag_a_d;
            mag_b_q     <= mag_b_d;
            neg_q       <= neg_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
endmodule

// File: tb/tb_mult32_seq.sv
// Randomized and directed checks of mult32_seq against a plain 64-bit arithmetic model.
module tb_mult32_seq;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [1:0]  op;
    logic [31:0] operand_a, operand_b, result;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];
    logic prev_hold = 1'b0;

    always #5 clk = ~clk;

    mult32_seq dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    // Reference: sign- or zero-extend to 64 bits, multiply, pick a half.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] p;
        sa = (o == 2'b01 || o == 2'b10) ? longint'($signed(a)) : longint'({32'b0, a});
        sb = (o == 2'b01) ? longint'($signed(b)) : longint'({32'b0, b});
        p  = 64'(sa * sb);
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Compare process: every cycle the result is presented it must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_hold) chk("valid_held", {31'b0, out_valid}, 32'd1);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", {31'b0, out_valid}, 32'd0);
                end else begin
                    chk("result", result, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
        prev_hold = out_valid && !out_ready && !rst && !flush;
    end

    // Latency counts the accepting edge as edge 1.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input bit poke);
        int edges;
        chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        @(posedge clk);
        exp_q.push_back(model(o, a, b));
        #1;
        in_valid  = 1'b0;
        operand_a = $urandom;
        operand_b = $urandom;
        op        = 2'($urandom);
        edges = 1;
        while (!out_valid && edges < 20) begin
            tick();
            edges++;
        end
        chk("latency_edges", 32'(edges), 32'd6);
        for (int i = 0; i < hold; i++) begin
            chk("busy_in_ready", {31'b0, in_ready}, 32'd0);
            if (poke) begin
                in_valid  = 1'b1;
                op        = 2'($urandom);
                operand_a = $urandom;
                operand_b = $urandom;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("in_ready_after_hs", {31'b0, in_ready}, 32'd1);
        chk("out_valid_after_hs", {31'b0, out_valid}, 32'd0);
    endtask

    logic [1:0]  d_op  [9] = '{2'b11, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 2'b00};
    logic [31:0] d_a   [9] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'd7, 32'd7,
                               32'hFFFFFFFF, 32'h12345678, 32'd3, 32'd3};
    logic [31:0] d_b   [9] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFD, 32'hFFFFFFFD,
                               32'hFFFFFFFF, 32'h00000010, 32'd5, 32'd5};
    logic [31:0] d_exp [9] = '{32'hFFFFFFFE, 32'h00000001, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFEB,
                               32'hFFFFFFFF, 32'h23456780, 32'h00000000, 32'h0000000F};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int edges;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 2'b00; operand_a = '0; operand_b = '0;
        tick(); tick();
        rst = 1'b0;
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_result", result, 32'd0);

        // Directed vectors; the first also exercises backpressure with ignored requests.
        for (int i = 0; i < 7; i++) begin
            chk("model_pin", model(d_op[i], d_a[i], d_b[i]), d_exp[i]);
            run_op(d_op[i], d_a[i], d_b[i], (i == 0) ? 3 : 0, (i == 0));
        end

        // A request alongside flush must not be taken.
        in_valid = 1'b1; flush = 1'b1; op = 2'b00; operand_a = 32'd9; operand_b = 32'd9;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_blocks_accept", {31'b0, in_ready}, 32'd1);

        // Kill in the second CALC cycle.
        in_valid = 1'b1; op = 2'b01; operand_a = $urandom; operand_b = $urandom;
        tick();
        in_valid = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
        chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        repeat (8) tick();
        chk("flush_no_result", {31'b0, out_valid}, 32'd0);
        for (int i = 7; i < 9; i++) begin
            chk("model_pin", model(d_op[i], d_a[i], d_b[i]), d_exp[i]);
            run_op(d_op[i], d_a[i], d_b[i], 1, 1'b0);
        end

        // Reset while holding a result.
        in_valid = 1'b1; op = 2'b11; operand_a = 32'hDEADBEEF; operand_b = 32'hCAFEF00D;
        @(posedge clk);
        exp_q.push_back(model(2'b11, 32'hDEADBEEF, 32'hCAFEF00D));
        #1;
        in_valid = 1'b0;
        edges = 1;
        while (!out_valid && edges < 20) begin
            tick();
            edges++;
        end
        chk("rst_case_latency", 32'(edges), 32'd6);
        tick();
        rst = 1'b1;
        tick();
        exp_q.delete();
        rst = 1'b0;
        chk("rst_done_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_done_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_done_result", result, 32'd0);

        for (int n = 0; n < 40; n++) begin
            run_op(2'($urandom), pick_operand(), pick_operand(),
                   int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end

        tick(); tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
